// File: rtl/vga_fetch_pkg.sv
// Shared types for the VGA frame-buffer fetch scheduler: FSM states, pixel word
// layout and byte-lane offsets.
package vga_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_e;

   localparam int BRIGHT_LSB = 24;
   localparam int RED_LSB    = 16;
   localparam int GREEN_LSB  = 8;
   localparam int BLUE_LSB   = 0;

   typedef logic [31:0] pixel_word_t;

endpackage

// File: rtl/vga_fifo_fwft.sv
// Show-ahead (first-word-fall-through) pixel FIFO with synchronous flush.
// rd_data always presents the head entry; it is meaningful only while empty=0.
module vga_fifo_fwft #(
   parameter int C_depth = 32,
   parameter int C_width = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [C_width-1:0]         wr_data,
   input  logic                       rd_en,
   output logic [C_width-1:0]         rd_data,
   output logic [$clog2(C_depth):0]   count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(C_depth);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(C_depth);

   logic [C_width-1:0] mem_q [C_depth];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a write into a full FIFO is
   // accepted when it coincides with a read.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/vga_fetch_sched.sv
// Frame-buffer fetch scheduler: bursts frame words into a show-ahead pixel FIFO,
// restarts on vsync, rewinds on line_repeat. Optional stats: VGA_FETCH_STATS_EN.
module vga_fetch_sched
   import vga_fetch_pkg::*;
#(
   parameter int C_addr_bits  = 30,
   parameter int C_fifo_depth = 32,
   parameter int C_burst_len  = 8,
   parameter int C_line_words = 640,
   parameter int C_lines      = 480
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [C_addr_bits-1:0]         base_addr,
   output logic                           addr_strobe,
   output logic [C_addr_bits-1:0]         addr,
   input  logic                           data_ready,
   input  logic [31:0]                    data_in,
   input  logic                           fetch_next,
   input  logic                           line_repeat,
   input  logic                           vsync,
   output logic [7:0]                     red_byte,
   output logic [7:0]                     green_byte,
   output logic [7:0]                     blue_byte,
   output logic [7:0]                     bright_byte,
   output logic                           underflow,
   output logic                           underflow_sticky,
   output logic [15:0]                    underflow_count,
   output logic [1:0]                     dbg_state,
   output logic [$clog2(C_fifo_depth):0]  dbg_fifo_count
);

   localparam int FRAME_WORDS = C_line_words * C_lines;
   localparam int WL_W  = $clog2(FRAME_WORDS + 1);
   localparam int BC_W  = $clog2(C_burst_len + 1);
   localparam int LW_W  = (C_line_words > 1) ? $clog2(C_line_words) : 1;
   localparam int LN_W  = (C_lines > 1) ? $clog2(C_lines) : 1;
   localparam int CNT_W = $clog2(C_fifo_depth) + 1;

   localparam logic [WL_W-1:0]        FRAME_W    = WL_W'(FRAME_WORDS);
   localparam logic [WL_W-1:0]        BURST_WL   = WL_W'(C_burst_len);
   localparam logic [BC_W-1:0]        BURST_BC   = BC_W'(C_burst_len);
   localparam logic [CNT_W-1:0]       FILL_LIMIT = CNT_W'(C_fifo_depth - C_burst_len);
   localparam logic [LW_W-1:0]        LAST_WORD  = LW_W'(C_line_words - 1);
   localparam logic [LN_W-1:0]        LAST_LINE  = LN_W'(C_lines - 1);
   localparam logic [C_addr_bits-1:0] ADDR_ONE   = C_addr_bits'(1);

   fetch_state_e            state_q, state_d;
   logic                    strobe_q, strobe_d;
   logic [C_addr_bits-1:0]  addr_q, addr_d;
   logic [BC_W-1:0]         burst_cnt_q, burst_cnt_d;
   logic [WL_W-1:0]         words_left_q, words_left_d;
   logic                    vsync_q, lrep_q;
   logic [LW_W-1:0]         rd_word_q, rd_word_d;
   logic [LN_W-1:0]         rd_line_q, rd_line_d;
   logic [C_addr_bits-1:0]  rd_addr_q, rd_addr_d;
   logic [C_addr_bits-1:0]  rewind_addr_q, rewind_addr_d;
   logic [LN_W-1:0]         rewind_line_q, rewind_line_d;
   pixel_word_t             last_pix_q, last_pix_d;
   logic                    underflow_q, underflow_d;

   logic                    vs_edge, lr_edge, restart;
   logic                    fifo_wr, pop;
   pixel_word_t             fifo_head, pix;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty, fifo_full;

   // vsync beats a coincident line_repeat edge.
   assign vs_edge = vsync && !vsync_q;
   assign lr_edge = line_repeat && !lrep_q && !vs_edge;
   assign restart = vs_edge || lr_edge;

   // Handshake: addr_strobe is a registered request held for the whole burst;
   // each cycle with addr_strobe=1 and data_ready=1 transfers data_in for addr.
   assign fifo_wr = (state_q == ST_BURST) && data_ready && !restart;
   assign pop     = fetch_next && !fifo_empty && !restart;

   vga_fifo_fwft #(
      .C_depth (C_fifo_depth),
      .C_width (32)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .flush   (restart),
      .wr_en   (fifo_wr),
      .wr_data (data_in),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_comb begin
      state_d       = state_q;
      strobe_d      = strobe_q;
      addr_d        = addr_q;
      burst_cnt_d   = burst_cnt_q;
      words_left_d  = words_left_q;
      rd_word_d     = rd_word_q;
      rd_line_d     = rd_line_q;
      rd_addr_d     = rd_addr_q;
      rewind_addr_d = rewind_addr_q;
      rewind_line_d = rewind_line_q;
      last_pix_d    = last_pix_q;
      underflow_d   = fetch_next && fifo_empty;

      if (vs_edge) begin
         state_d      = ST_IDLE;
         strobe_d     = 1'b0;
         burst_cnt_d  = '0;
         addr_d       = base_addr;
         words_left_d = FRAME_W;
         rd_word_d    = '0;
         rd_line_d    = '0;
         rd_addr_d    = base_addr;
      end else if (lr_edge) begin
         state_d      = ST_IDLE;
         strobe_d     = 1'b0;
         burst_cnt_d  = '0;
         addr_d       = rewind_addr_q;
         words_left_d = WL_W'(FRAME_WORDS - int'(rewind_line_q) * C_line_words);
         rd_word_d    = '0;
         rd_line_d    = rewind_line_q;
         rd_addr_d    = rewind_addr_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (words_left_q != '0 && fifo_count <= FILL_LIMIT) begin
                  state_d     = ST_BURST;
                  strobe_d    = 1'b1;
                  burst_cnt_d = (words_left_q < BURST_WL) ? BC_W'(words_left_q) : BURST_BC;
               end
            end
            ST_BURST: begin
               if (data_ready) begin
                  addr_d       = addr_q + ADDR_ONE;
                  burst_cnt_d  = burst_cnt_q - BC_W'(1);
                  words_left_d = words_left_q - WL_W'(1);
                  if (burst_cnt_q == BC_W'(1)) begin
                     strobe_d = 1'b0;
                     state_d  = (words_left_q == WL_W'(1)) ? ST_DONE : ST_IDLE;
                  end
               end
            end
            default: strobe_d = 1'b0;
         endcase

         // Read side: the first pop of each line records where to rewind to.
         if (pop) begin
            last_pix_d = fifo_head;
            rd_addr_d  = rd_addr_q + ADDR_ONE;
            if (rd_word_q == '0) begin
               rewind_addr_d = rd_addr_q;
               rewind_line_d = rd_line_q;
            end
            if (rd_word_q == LAST_WORD) begin
               rd_word_d = '0;
               rd_line_d = (rd_line_q == LAST_LINE) ? '0 : rd_line_q + LN_W'(1);
            end else begin
               rd_word_d = rd_word_q + LW_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         strobe_q      <= 1'b0;
         addr_q        <= '0;
         burst_cnt_q   <= '0;
         words_left_q  <= '0;
         vsync_q       <= 1'b0;
         lrep_q        <= 1'b0;
         rd_word_q     <= '0;
         rd_line_q     <= '0;
         rd_addr_q     <= '0;
         rewind_addr_q <= '0;
         rewind_line_q <= '0;
         last_pix_q    <= '0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         strobe_q      <= strobe_d;
         addr_q        <= addr_d;
         burst_cnt_q   <= burst_cnt_d;
         words_left_q  <= words_left_d;
         vsync_q       <= vsync;
         lrep_q        <= line_repeat;
         rd_word_q     <= rd_word_d;
         rd_line_q     <= rd_line_d;
         rd_addr_q     <= rd_addr_d;
         rewind_addr_q <= rewind_addr_d;
         rewind_line_q <= rewind_line_d;
         last_pix_q    <= last_pix_d;
         underflow_q   <= underflow_d;
      end
   end

   // An empty FIFO shows the last popped pixel so the display holds steady.
   assign pix         = fifo_empty ? last_pix_q : fifo_head;
   assign bright_byte = pix[BRIGHT_LSB +: 8];
   assign red_byte    = pix[RED_LSB +: 8];
   assign green_byte  = pix[GREEN_LSB +: 8];
   assign blue_byte   = pix[BLUE_LSB +: 8];

   assign addr_strobe    = strobe_q;
   assign addr           = addr_q;
   assign underflow      = underflow_q;
   assign dbg_state      = state_q;
   assign dbg_fifo_count = fifo_count;

   overflow_chk : assert property (@(posedge clk) disable iff (reset)
      !(fifo_wr && fifo_full && !pop));

`ifdef VGA_FETCH_STATS_EN
   logic        sticky_q, sticky_d;
   logic [15:0] ucount_q, ucount_d;

   always_comb begin
      sticky_d = sticky_q;
      ucount_d = ucount_q;
      if (vs_edge) sticky_d = 1'b0;
      if (underflow_d) begin
         sticky_d = 1'b1;
         if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_q <= 1'b0;
         ucount_q <= '0;
      end else begin
         sticky_q <= sticky_d;
         ucount_q <= ucount_d;
      end
   end

   assign underflow_sticky = sticky_q;
   assign underflow_count  = ucount_q;
`else
   assign underflow_sticky = 1'b0;
   assign underflow_count  = '0;
`endif

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench for vga_fetch_sched (16 words x 4 lines, burst 8, FIFO 32).
// Memory model: data_in is a fixed function of addr.
module tb_vga_fetch_sched;
   import vga_fetch_pkg::*;

   localparam int AW = 30;
   localparam int LW = 16;
   localparam int NL = 4;
   localparam int FD = 32;
   localparam int BL = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] base_addr;
   logic          addr_strobe;
   logic [AW-1:0] addr;
   logic          data_ready;
   logic [31:0]   data_in;
   logic          fetch_next, line_repeat, vsync;
   logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
   logic          underflow, underflow_sticky;
   logic [15:0]   underflow_count;
   logic [1:0]    dbg_state;
   logic [5:0]    dbg_fifo_count;
   logic [31:0]   pix_obs;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   vga_fetch_sched #(
      .C_addr_bits (AW), .C_fifo_depth (FD), .C_burst_len (BL),
      .C_line_words (LW), .C_lines (NL)
   ) dut (
      .clk (clk), .reset (reset), .base_addr (base_addr),
      .addr_strobe (addr_strobe), .addr (addr), .data_ready (data_ready),
      .data_in (data_in), .fetch_next (fetch_next), .line_repeat (line_repeat),
      .vsync (vsync), .red_byte (red_byte), .green_byte (green_byte),
      .blue_byte (blue_byte), .bright_byte (bright_byte), .underflow (underflow),
      .underflow_sticky (underflow_sticky), .underflow_count (underflow_count),
      .dbg_state (dbg_state), .dbg_fifo_count (dbg_fifo_count)
   );

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {a[7:0] ^ 8'h5A, a[15:8] + 8'h11, a[7:0] + 8'd3, ~a[7:0]};
   endfunction

   assign data_in = mem_word(addr);
   assign pix_obs = {bright_byte, red_byte, green_byte, blue_byte};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [AW-1:0] b);
      vsync = 1'b1;
      base_addr = b;
      tick();
      vsync = 1'b0;
   endtask

   // Holds fetch_next for n cycles, comparing each head pixel against exp_q.
   task automatic stream(input string tag, input int n);
      fetch_next = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() != 0) chk(tag, pix_obs, exp_q.pop_front());
         chk({tag, "_uf"}, {31'b0, underflow}, 32'd0);
         tick();
      end
      fetch_next = 1'b0;
      chk({tag, "_uf_end"}, {31'b0, underflow}, 32'd0);
   endtask

   initial begin
      int seen;
      int run;
      int acc;
      logic [AW-1:0] exp_a;

      reset = 1'b1; vsync = 1'b0; line_repeat = 1'b0; fetch_next = 1'b0;
      data_ready = 1'b0; base_addr = '0;
      repeat (3) tick();
      chk("rst_strobe", {31'b0, addr_strobe}, 32'd0);
      chk("rst_addr", {2'b0, addr}, 32'd0);
      chk("rst_pix", pix_obs, 32'd0);
      chk("rst_uf", {31'b0, underflow}, 32'd0);
      chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      chk("rst_fifo", {26'b0, dbg_fifo_count}, 32'd0);

      reset = 1'b0;
      data_ready = 1'b1;
      seen = 0;
      repeat (10) begin tick(); if (addr_strobe) seen++; end
      chk("no_fetch_before_vsync", seen, 32'd0);

      // Burst shape from a fresh frame.
      start_frame(30'h100);
      chk("vs_addr", {2'b0, addr}, 32'h100);
      tick();
      chk("first_strobe", {31'b0, addr_strobe}, 32'd1);
      exp_a = 30'h100; run = 0; acc = 0;
      for (int c = 0; c < 45; c++) begin
         if (addr_strobe) begin
            chk("burst_addr", {2'b0, addr}, {2'b0, exp_a});
            exp_a++; run++; acc++;
         end else if (run != 0) begin
            chk("burst_len", run, BL);
            run = 0;
         end
         tick();
      end
      chk("words_fetched", acc, 32'd32);
      chk("fifo_full_level", {26'b0, dbg_fifo_count}, 32'd32);
      chk("show_ahead", pix_obs, mem_word(30'h100));

      // vsync edge on the 3rd accepted word of a burst.
      start_frame(30'h200);
      chk("vs_flush", {26'b0, dbg_fifo_count}, 32'd0);
      tick();
      chk("mid_strobe", {31'b0, addr_strobe}, 32'd1);
      tick(); tick();
      chk("mid_two_words", {26'b0, dbg_fifo_count}, 32'd2);
      chk("mid_addr", {2'b0, addr}, 32'h202);
      vsync = 1'b1; base_addr = 30'h300;
      tick();
      vsync = 1'b0;
      chk("mid_vs_strobe", {31'b0, addr_strobe}, 32'd0);
      chk("mid_vs_fifo", {26'b0, dbg_fifo_count}, 32'd0);
      chk("mid_vs_addr", {2'b0, addr}, 32'h300);
      tick();
      chk("mid_restart_strobe", {31'b0, addr_strobe}, 32'd1);
      chk("mid_restart_addr", {2'b0, addr}, 32'h300);

      // Asynchronous reset during a burst.
      #3 reset = 1'b1;
      #1;
      chk("arst_strobe", {31'b0, addr_strobe}, 32'd0);
      chk("arst_addr", {2'b0, addr}, 32'd0);
      chk("arst_pix", pix_obs, 32'd0);
      chk("arst_uf", {31'b0, underflow}, 32'd0);
      chk("arst_fifo", {26'b0, dbg_fifo_count}, 32'd0);
      chk("arst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      tick();
      reset = 1'b0;
      seen = 0;
      repeat (20) begin tick(); if (addr_strobe) seen++; end
      chk("arst_no_strobe", seen, 32'd0);
      chk("arst_ucount", {16'b0, underflow_count}, 32'd0);

      // Whole 64-word frame consumed in order.
      start_frame(30'h400);
      repeat (45) tick();
      chk("frame_prefill", {26'b0, dbg_fifo_count}, 32'd32);
      for (int i = 0; i < LW * NL; i++) exp_q.push_back(mem_word(30'h400 + i));
      stream("frame_pix", LW * NL);
      tick();
      chk("frame_done", {30'b0, dbg_state}, {30'b0, ST_DONE});
      chk("frame_drained", {26'b0, dbg_fifo_count}, 32'd0);
      chk("frame_hold", pix_obs, mem_word(30'h43F));
      seen = 0;
      repeat (10) begin tick(); if (addr_strobe) seen++; end
      chk("done_no_strobe", seen, 32'd0);

      // line_repeat after line 1 fully consumed.
      start_frame(30'h800);
      repeat (45) tick();
      for (int i = 0; i < 2 * LW; i++) exp_q.push_back(mem_word(30'h800 + i));
      stream("lines01_pix", 2 * LW);
      line_repeat = 1'b1;
      tick();
      chk("lr_fifo", {26'b0, dbg_fifo_count}, 32'd0);
      chk("lr_strobe", {31'b0, addr_strobe}, 32'd0);
      chk("lr_addr", {2'b0, addr}, 32'h810);
      tick();
      line_repeat = 1'b0;
      chk("lr_req_strobe", {31'b0, addr_strobe}, 32'd1);
      chk("lr_req_addr", {2'b0, addr}, 32'h810);
      repeat (45) tick();
      for (int i = 0; i < LW; i++) exp_q.push_back(mem_word(30'h810 + i));
      stream("line1_again", LW);

      // Memory stalled, FIFO empty, fetch_next held for 100 cycles.
      data_ready = 1'b0;
      start_frame(30'hC00);
      chk("uf_flush", {26'b0, dbg_fifo_count}, 32'd0);
      chk("uf_hold_start", pix_obs, mem_word(30'h81F));
      fetch_next = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("uf_pulse", {31'b0, underflow}, 32'd1);
         chk("uf_hold", pix_obs, mem_word(30'h81F));
      end
      fetch_next = 1'b0;
      tick();
      chk("uf_stop", {31'b0, underflow}, 32'd0);
`ifdef VGA_FETCH_STATS_EN
      chk("uf_count", {16'b0, underflow_count}, 32'd100);
      chk("uf_sticky", {31'b0, underflow_sticky}, 32'd1);
      start_frame(30'hD00);
      chk("uf_sticky_clr", {31'b0, underflow_sticky}, 32'd0);
      chk("uf_count_keep", {16'b0, underflow_count}, 32'd100);
`else
      chk("uf_count_tied", {16'b0, underflow_count}, 32'd0);
      chk("uf_sticky_tied", {31'b0, underflow_sticky}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
